// File: rtl/int_ctrl_pkg.sv
// int_ctrl shared types: FSM state enum, source limit, default port IDs.
// Imported by the interrupt controller and its priority encoder.
package int_ctrl_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [7:0] MASK_ID_DEF = 8'h90;
  localparam logic [7:0] PEND_ID_DEF = 8'h91;
  localparam logic [7:0] ACK_ID_DEF  = 8'h92;
  localparam logic [7:0] VEC_ID_DEF  = 8'h93;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// MCU port bus seen by int_ctrl.
// master: PORT_ID/OUT_PORT/IO_STRB out, IN_PORT_DATA in; slave: reverse.
interface int_ctrl_if;

  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT_DATA;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_PORT_DATA
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_PORT_DATA
  );

endinterface

// File: rtl/int_prio_enc.sv
// Circular priority encoder over 8 requests starting at index start.
// Ports: req[8], start[3] in; valid, idx[3] out (first set bit found).
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [MAX_SRC-1:0] req,
  input  logic [2:0]         start,
  output logic               valid,
  output logic [2:0]         idx
);

  logic [2:0] j;

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    j     = 3'd0;
    for (int i = 0; i < MAX_SRC; i++) begin
      j = start + 3'(i);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Port-mapped interrupt controller: edge-detect, mask, priority, pulse.
// Ports: CLK, RESET_N (sync, low), IRQ_IN, INT_OUT, bus (slave).
// Build option INT_CTRL_ROTATE_PRIO_EN selects round-robin priority.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter int         PULSE_LEN = 2,
  parameter logic [7:0] MASK_ID   = MASK_ID_DEF,
  parameter logic [7:0] PEND_ID   = PEND_ID_DEF,
  parameter logic [7:0] ACK_ID    = ACK_ID_DEF,
  parameter logic [7:0] VEC_ID    = VEC_ID_DEF
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  output logic               INT_OUT,
  int_ctrl_if.slave          bus
);

  localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] req;
  logic [7:0]         mask8;
  logic [7:0]         pend8;
  logic [7:0]         req8;
  logic               mask_we;
  logic               in_service;
  logic               win_vld;
  logic [2:0]         win_idx;
  logic [2:0]         start;
  logic [2:0]         cur_src;
  logic [CW-1:0]      cnt;
  state_t             state;

  assign mask_we = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
  assign ack_clr = (bus.IO_STRB && (bus.PORT_ID == ACK_ID))
                 ? bus.OUT_PORT[NUM_SRC-1:0] : '0;
  assign rise    = IRQ_IN & ~irq_prev;
  assign req     = pending & mask;
  assign mask8   = 8'(mask);
  assign pend8   = 8'(pending);
  assign req8    = 8'(req);
  assign in_service = (state == WAIT_ACK);

`ifdef INT_CTRL_ROTATE_PRIO_EN
  logic [2:0] last_served;

  assign start = (last_served == 3'(NUM_SRC-1))
               ? 3'd0 : last_served + 3'd1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      last_served <= 3'(NUM_SRC-1);
    end else if (state == IDLE && win_vld) begin
      last_served <= win_idx;
    end
  end
`else
  assign start = 3'd0;
`endif

  int_prio_enc u_enc (
    .req   (req8),
    .start (start),
    .valid (win_vld),
    .idx   (win_idx)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      // Track the live level so a source held high gives no edge.
      irq_prev <= IRQ_IN;
      mask     <= '0;
      pending  <= '0;
      state    <= IDLE;
      cur_src  <= 3'd0;
      cnt      <= '0;
      INT_OUT  <= 1'b0;
    end else begin
      irq_prev <= IRQ_IN;
      if (mask_we) mask <= bus.OUT_PORT[NUM_SRC-1:0];
      // New edge beats a same-cycle acknowledge.
      pending <= (pending & ~ack_clr) | rise;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            cur_src <= win_idx;
            cnt     <= CW'(PULSE_LEN-1);
            state   <= ASSERT;
            INT_OUT <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == '0) begin
            state   <= WAIT_ACK;
            INT_OUT <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (!pend8[cur_src] || !mask8[cur_src]) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          INT_OUT <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.IN_PORT_DATA = 8'h00;
    unique case (1'b1)
      (bus.PORT_ID == MASK_ID): bus.IN_PORT_DATA = mask8;
      (bus.PORT_ID == PEND_ID): bus.IN_PORT_DATA = pend8;
      (bus.PORT_ID == VEC_ID):
        bus.IN_PORT_DATA = {in_service, 4'b0, cur_src};
      default: bus.IN_PORT_DATA = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
// Default parameters: 4 sources, 2-cycle pulse, IDs 0x90..0x93.
module tb_int_ctrl;

  localparam logic [7:0] MASK = 8'h90;
  localparam logic [7:0] PEND = 8'h91;
  localparam logic [7:0] ACK  = 8'h92;
  localparam logic [7:0] VEC  = 8'h93;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] IRQ_IN;
  logic       INT_OUT;
  int         tests = 0;
  int         fails = 0;

  int_ctrl_if bus ();

  int_ctrl dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .IRQ_IN  (IRQ_IN),
    .INT_OUT (INT_OUT),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] id,
                    input logic [7:0] exp);
    bus.PORT_ID = id;
    #1;
    chk8(tag, bus.IN_PORT_DATA, exp);
    bus.PORT_ID = 8'h00;
  endtask

  task automatic irq(input string tag, input logic exp);
    chk8(tag, {7'b0, INT_OUT}, {7'b0, exp});
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
  endtask

  initial begin
    RESET_N      = 1'b0;
    IRQ_IN       = 4'b0000;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    irq("rst_int", 1'b0);
    rd("rst_mask", MASK, 8'h00);
    rd("rst_pend", PEND, 8'h00);
    rd("rst_vec", VEC, 8'h00);

    // 1: single source, pulse, ack
    wr(MASK, 8'h0F);
    rd("t1_mask", MASK, 8'h0F);
    IRQ_IN = 4'b0100;
    tick();
    rd("t1_pend", PEND, 8'h04);
    irq("t1_int_k", 1'b0);
    tick();
    irq("t1_int_k1", 1'b1);
    tick();
    irq("t1_int_k2", 1'b1);
    tick();
    irq("t1_int_k3", 1'b0);
    rd("t1_vec", VEC, 8'h82);
    rd("t1_bad_id", 8'h94, 8'h00);
    IRQ_IN = 4'b0000;
    wr(ACK, 8'h04);
    rd("t1_pend_ack", PEND, 8'h00);
    tick();
    rd("t1_vec_ack", VEC, 8'h02);
    irq("t1_int_ack", 1'b0);
    tick();
    irq("t1_int_idle", 1'b0);

    // 2: simultaneous 1 and 3, lowest first
    IRQ_IN = 4'b1010;
    tick();
    rd("t2_pend", PEND, 8'h0A);
    tick();
    irq("t2_int1", 1'b1);
    rd("t2_vec1", VEC, 8'h01);
    tick();
    tick();
    irq("t2_int1_end", 1'b0);
    rd("t2_vec1w", VEC, 8'h81);
    IRQ_IN = 4'b0000;
    wr(ACK, 8'h02);
    rd("t2_pend_ack", PEND, 8'h08);
    tick();
    irq("t2_gap", 1'b0);
    tick();
    irq("t2_int3", 1'b1);
    rd("t2_vec3", VEC, 8'h03);
    tick();
    tick();
    rd("t2_vec3w", VEC, 8'h83);
    wr(ACK, 8'h08);
    tick();
    rd("t2_idle", VEC, 8'h03);

    // 3: masked source stays pending, unmask raises request
    wr(MASK, 8'h00);
    IRQ_IN = 4'b0001;
    tick();
    rd("t3_pend", PEND, 8'h01);
    tick();
    irq("t3_masked_a", 1'b0);
    tick();
    irq("t3_masked_b", 1'b0);
    wr(MASK, 8'h01);
    irq("t3_unmask_w", 1'b0);
    tick();
    irq("t3_unmask_p", 1'b1);
    rd("t3_vec", VEC, 8'h00);
    tick();
    tick();
    rd("t3_vecw", VEC, 8'h80);

    // 4: edge and ack on the same bit, same cycle
    IRQ_IN = 4'b0000;
    tick();
    IRQ_IN = 4'b0001;
    wr(ACK, 8'h01);
    rd("t4_pend", PEND, 8'h01);
    tick();
    rd("t4_vec", VEC, 8'h80);
    wr(ACK, 8'h01);
    rd("t4_pend_clr", PEND, 8'h00);
    tick();

    // 5: source held high across reset
    IRQ_IN = 4'b0011;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    rd("t5_pend", PEND, 8'h00);
    wr(MASK, 8'h0F);
    tick();
    tick();
    irq("t5_int", 1'b0);
    rd("t5_pend2", PEND, 8'h00);

    // 6: reset during pulse
    IRQ_IN = 4'b0000;
    tick();
    IRQ_IN = 4'b0100;
    tick();
    tick();
    irq("t6_pulse", 1'b1);
    RESET_N = 1'b0;
    tick();
    irq("t6_int", 1'b0);
    rd("t6_mask", MASK, 8'h00);
    rd("t6_pend", PEND, 8'h00);
    rd("t6_vec", VEC, 8'h00);
    RESET_N = 1'b1;
    tick();
    tick();
    irq("t6_after", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
